countdown_display: RTL and testbench
====================================

// Module: countdown_display
// PURPOSE
//  Consumes the five countdown values (TLsec..PRsec) from the traffic-light state machine.
//  Converts each one to two BCD digits with a shared sequential converter.
//  Drives a 10-digit multiplexed common-anode 7-segment display, 2 digits per channel:
//  digits 0..9 = TL tens,units, TM, TR, PL, PR. Sits directly downstream of the light
//  controller, on the same clock.
// PARAMETERS
//  TW          6       width of TLsec/TMsec/TRsec
//  PW          6       width of PLsec/PRsec
//  ScanDiv     50_000  clock cycles each digit is lit (1 ms at 20 ns)
//  RefreshDiv  500_000 clock cycles between conversion sweeps (10 ms)
//  BlinkDiv    12_500_000 cycles per blink half-period (250 ms); used only with blink feature
// PORTS
//  Clock     in   1    system clock
//  Reset     in   1    asynchronous, active-high
//  TLsec     in   TW   traffic-left seconds remaining
//  TMsec     in   TW   traffic-mid seconds remaining
//  TRsec     in   TW   traffic-right seconds remaining
//  PLsec     in   PW   pedestrian-left seconds remaining
//  PRsec     in   PW   pedestrian-right seconds remaining
//  Seg       out  7    {g,f,e,d,c,b,a}, active-low
//  DigitSel  out  10   one-hot active-low digit enable
//  Busy      out  1    high while a conversion sweep is in progress
// BEHAVIOUR
//  Reset (async): Seg=7'h7F, DigitSel=10'h3FF, Busy=0, all stored digits=BLANK,
//   scan index=0, dividers=0, FSM=IDLE. Reset mid-sweep aborts; nothing is committed.
//  Sweep FSM: IDLE -> SNAP -> CONV -> NEXT -> (CONV | COMMIT) -> IDLE.
//   IDLE: wait for refresh divider terminal count (RefreshDiv-1), then go to SNAP.
//   SNAP: latch all 5 inputs in one cycle, zero-extended to W=max(TW,PW); ch=0; Busy=1.
//   CONV: pulse Start to bin2bcd_seq with snapshot[ch]; wait for Done.
//   NEXT: store result in shadow[ch]; ch++; ch==5 -> COMMIT, else -> CONV.
//   COMMIT: copy shadow -> display regs in one cycle (no torn display); Busy=0.
//  bin2bcd_seq: double-dabble, saturating at 2 digits. Start is sampled in cycle 0.
//   W shift cycles follow. Done is a 1-cycle pulse at cycle W+1. Start while busy is ignored.
//  Digit rules per channel value v:
//   v>99: both digits show dash (7'b011_1111).
//   v<=9: tens digit BLANK (leading-zero blank); units shown; v=0 shows "0" on units only.
//  Sweep latency: input change -> display <= RefreshDiv + 5*(W+3) + 3 cycles.
//  Scan: scan divider counts to ScanDiv-1, then the index advances; 9 wraps to 0.
//   DigitSel = ~(10'b1 << index).
//   Seg is forced to 7'h7F for the first cycle after each index change (anti-ghosting).
//   Seg and DigitSel are registered.
//  A COMMIT coinciding with a scan advance: the new digit shows committed data on the
//   cycle after blanking.
//  Inputs are sampled only in SNAP. Input changes during a sweep take effect next sweep.
// CONFIGURATION
//  `COUNTDOWN_DISPLAY_BLINK_EN defined:
//   A channel with committed value 1..3 has both its digits forced blank during alternate
//   BlinkDiv half-periods. The blink phase starts visible after reset.
//   Values 0 and >3 never blink.
//  Not defined: the blink divider and phase logic are absent; digits are always shown per
//   the rules above. BlinkDiv is unused.
// STRUCTURE
//  countdown_display_pkg: sweep state enum; SEG_BLANK=7'h7F; SEG_DASH;
//   function seg7(input logic [3:0] bcd) returning active-low pattern (0..9, 4'hE=dash,
//   4'hF=blank); NUM_CH=5, NUM_DIG=10.
//  Sub-module bin2bcd_seq #(W): Clock, Reset, Start, Bin[W-1:0] -> Done, Tens[3:0],
//   Units[3:0], Over.
//  Everything else (FSM, dividers, scan mux, blink) stays in countdown_display.
// TESTING (sim params: ScanDiv=4, RefreshDiv=64, BlinkDiv=32, TW=PW=6)
//  Reset, then release; inputs TL=20 TM=42 TR=7 PL=46 PR=0.
//   -> after first COMMIT the scan reads digits "2","0","4","2",blank,"7","4","6",blank,"0".
//  Check scan timing.
//   -> each DigitSel low for exactly 4 cycles; index 9 wraps to 0.
//   -> Seg=7'h7F in the first cycle of every digit.
//  Drive TL=63 (TW=6 max).
//   -> still under 99, shows "63". Force the bin2bcd_seq bench with W=7, Bin=120:
//      Over=1, Done at cycle 8.
//  Change TL from 20 to 19 during CONV of channel 2.
//   -> current commit still shows 20; the next sweep shows 19. No partial update is seen.
//  Assert Reset for 1 cycle mid-sweep (Busy=1).
//   -> Seg=7'h7F and DigitSel=10'h3FF immediately (async); Busy=0.
//   -> the next sweep recovers with correct digits.
//  With COUNTDOWN_DISPLAY_BLINK_EN and PR=2: PR units alternates "2"/blank every 32 cycles.
//   -> TL=20 never blanks.
//   -> without the macro, PR=2 is steady.

Source files
------------

// File: rtl/countdown_display_pkg.sv
// Shared sweep-state type, segment constants and the BCD-to-segment decoder.
// The optional blink feature is enabled by COUNTDOWN_DISPLAY_BLINK_EN.
package countdown_display_pkg;

    localparam int unsigned NUM_CH  = 5;
    localparam int unsigned NUM_DIG = 10;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b011_1111;
    localparam logic [3:0] BCD_DASH  = 4'hE;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [2:0] {IDLE, SNAP, CONV, NEXT, COMMIT} sweep_state_e;

    // Active-low {g,f,e,d,c,b,a}; codes A..D fall through to blank.
    function automatic logic [6:0] seg7(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:     seg = 7'h40;
            4'd1:     seg = 7'h79;
            4'd2:     seg = 7'h24;
            4'd3:     seg = 7'h30;
            4'd4:     seg = 7'h19;
            4'd5:     seg = 7'h12;
            4'd6:     seg = 7'h02;
            4'd7:     seg = 7'h78;
            4'd8:     seg = 7'h00;
            4'd9:     seg = 7'h10;
            BCD_DASH: seg = SEG_DASH;
            default:  seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/countdown_display_bin2bcd_seq.sv
// Sequential double-dabble converter to two BCD digits; values above 99 raise Over
// and report 9,9. Start is ignored while a conversion is running.
module bin2bcd_seq #(
    parameter int unsigned W = 6
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Start,
    input  logic [W-1:0] Bin,
    output logic         Done,
    output logic [3:0]   Tens,
    output logic [3:0]   Units,
    output logic         Over
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  bin_q;
    logic [7:0]    bcd_q;
    logic          over_q;
    logic          done_q;
    logic [CW-1:0] cnt_q;

    logic [7:0]    adj_c;
    logic [7:0]    bcd_nxt_c;
    logic          over_nxt_c;

    // One add-3/shift step; a bit leaving the tens digit means the value is >= 100.
    always_comb begin
        adj_c = bcd_q;
        if (adj_c[3:0] >= 4'd5) adj_c[3:0] = adj_c[3:0] + 4'd3;
        if (adj_c[7:4] >= 4'd5) adj_c[7:4] = adj_c[7:4] + 4'd3;
        bcd_nxt_c  = {adj_c[6:0], bin_q[W-1]};
        over_nxt_c = over_q | adj_c[7];
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            bin_q  <= '0;
            bcd_q  <= '0;
            over_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (cnt_q == '0) begin
                if (Start) begin
                    bin_q  <= Bin;
                    bcd_q  <= '0;
                    over_q <= 1'b0;
                    cnt_q  <= CW'(W);
                end
            end else begin
                bin_q  <= bin_q << 1;
                over_q <= over_nxt_c;
                cnt_q  <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    done_q <= 1'b1;
                    bcd_q  <= over_nxt_c ? 8'h99 : bcd_nxt_c;
                end else begin
                    bcd_q  <= bcd_nxt_c;
                end
            end
        end
    end

    assign Done  = done_q;
    assign Tens  = bcd_q[7:4];
    assign Units = bcd_q[3:0];
    assign Over  = over_q;

endmodule

// File: rtl/countdown_display.sv
// Five countdown channels -> shared BCD conversion sweep -> 10-digit multiplexed display.
// Define COUNTDOWN_DISPLAY_BLINK_EN to blink channels showing 1..3.
module countdown_display
    import countdown_display_pkg::*;
#(
    parameter int unsigned TW         = 6,
    parameter int unsigned PW         = 6,
    parameter int unsigned ScanDiv    = 50_000,
    parameter int unsigned RefreshDiv = 500_000,
    parameter int unsigned BlinkDiv   = 12_500_000
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [TW-1:0]      TLsec,
    input  logic [TW-1:0]      TMsec,
    input  logic [TW-1:0]      TRsec,
    input  logic [PW-1:0]      PLsec,
    input  logic [PW-1:0]      PRsec,
    output logic [6:0]         Seg,
    output logic [NUM_DIG-1:0] DigitSel,
    output logic               Busy
);

    localparam int unsigned W   = (TW > PW) ? TW : PW;
    localparam int unsigned SW  = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
    localparam int unsigned RW  = (RefreshDiv > 1) ? $clog2(RefreshDiv) : 1;
    localparam int unsigned IW  = $clog2(NUM_DIG);
    localparam int unsigned CHW = $clog2(NUM_CH);

    sweep_state_e                   state_q, state_d;
    logic [RW-1:0]                  ref_cnt_q;
    logic                           ref_tc_c;
    logic [NUM_CH-1:0][W-1:0]       snap_q;
    logic [CHW-1:0]                 ch_q;
    logic [NUM_DIG-1:0][3:0]        shadow_q;
    logic [NUM_DIG-1:0][3:0]        disp_q;
    logic                           conv_start_q;
    logic                           busy_q;
    logic                           conv_done;
    logic                           conv_over;
    logic [3:0]                     conv_tens;
    logic [3:0]                     conv_units;
    logic [3:0]                     tens_code_c;
    logic [3:0]                     units_code_c;
    logic [SW-1:0]                  scan_cnt_q;
    logic                           scan_tc_c;
    logic [IW-1:0]                  idx_q;
    logic [IW-1:0]                  idx_nxt_c;
    logic [6:0]                     seg_q;
    logic [6:0]                     digit_seg_c;
    logic [NUM_DIG-1:0]             sel_q;

    bin2bcd_seq #(.W(W)) u_bin2bcd (
        .Clock (Clock),
        .Reset (Reset),
        .Start (conv_start_q),
        .Bin   (snap_q[ch_q]),
        .Done  (conv_done),
        .Tens  (conv_tens),
        .Units (conv_units),
        .Over  (conv_over)
    );

    assign ref_tc_c = (ref_cnt_q == RW'(RefreshDiv - 1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ref_tc_c) state_d = SNAP;
            SNAP:    state_d = CONV;
            CONV:    if (conv_done) state_d = NEXT;
            NEXT:    state_d = (ch_q == CHW'(NUM_CH - 1)) ? COMMIT : CONV;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Over -> two dashes; a zero tens digit is blanked so single digits show on units only.
    always_comb begin
        tens_code_c  = conv_tens;
        units_code_c = conv_units;
        if (conv_over) begin
            tens_code_c  = BCD_DASH;
            units_code_c = BCD_DASH;
        end else if (conv_tens == 4'd0) begin
            tens_code_c  = BCD_BLANK;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ref_cnt_q    <= '0;
            snap_q       <= '0;
            ch_q         <= '0;
            shadow_q     <= {NUM_DIG{BCD_BLANK}};
            disp_q       <= {NUM_DIG{BCD_BLANK}};
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ref_cnt_q    <= ref_tc_c ? '0 : ref_cnt_q + RW'(1);
            conv_start_q <= (state_d == CONV) && (state_q != CONV);
            busy_q       <= state_d inside {SNAP, CONV, NEXT};
            case (state_q)
                SNAP: begin
                    snap_q[0] <= W'(TLsec);
                    snap_q[1] <= W'(TMsec);
                    snap_q[2] <= W'(TRsec);
                    snap_q[3] <= W'(PLsec);
                    snap_q[4] <= W'(PRsec);
                    ch_q      <= '0;
                end
                NEXT: begin
                    shadow_q[{ch_q, 1'b0}] <= tens_code_c;
                    shadow_q[{ch_q, 1'b1}] <= units_code_c;
                    ch_q                   <= ch_q + CHW'(1);
                end
                COMMIT:  disp_q <= shadow_q;
                default: ;
            endcase
        end
    end

`ifdef COUNTDOWN_DISPLAY_BLINK_EN
    localparam int unsigned BW = (BlinkDiv > 1) ? $clog2(BlinkDiv) : 1;

    logic [BW-1:0]     blink_cnt_q;
    logic              phase_q;
    logic [NUM_CH-1:0] shadow_blink_q;
    logic [NUM_CH-1:0] disp_blink_q;
    logic              blink_ok_c;

    assign blink_ok_c = !conv_over && (conv_tens == 4'd0) &&
                        (conv_units inside {4'd1, 4'd2, 4'd3});

    // Blink flags travel with the digits so they commit in the same cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            blink_cnt_q    <= '0;
            phase_q        <= 1'b0;
            shadow_blink_q <= '0;
            disp_blink_q   <= '0;
        end else begin
            if (blink_cnt_q == BW'(BlinkDiv - 1)) begin
                blink_cnt_q <= '0;
                phase_q     <= ~phase_q;
            end else begin
                blink_cnt_q <= blink_cnt_q + BW'(1);
            end
            if (state_q == NEXT)   shadow_blink_q[ch_q] <= blink_ok_c;
            if (state_q == COMMIT) disp_blink_q         <= shadow_blink_q;
        end
    end

    assign digit_seg_c = (phase_q && disp_blink_q[idx_q[IW-1:1]]) ? SEG_BLANK
                                                                   : seg7(disp_q[idx_q]);
`else
    // BlinkDiv has no effect without the blink feature.
    logic unused_blink;
    assign unused_blink = (BlinkDiv == 0);
    assign digit_seg_c  = seg7(disp_q[idx_q]);
`endif

    assign scan_tc_c = (scan_cnt_q == SW'(ScanDiv - 1));
    assign idx_nxt_c = (idx_q == IW'(NUM_DIG - 1)) ? '0 : idx_q + IW'(1);

    // Digit scan; Seg is blanked for the first cycle of each new digit to avoid ghosting.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            sel_q      <= '1;
        end else begin
            scan_cnt_q <= scan_tc_c ? '0 : scan_cnt_q + SW'(1);
            if (scan_tc_c) begin
                idx_q <= idx_nxt_c;
                sel_q <= ~(NUM_DIG'(1) << idx_nxt_c);
                seg_q <= SEG_BLANK;
            end else begin
                sel_q <= ~(NUM_DIG'(1) << idx_q);
                seg_q <= digit_seg_c;
            end
        end
    end

    assign Seg      = seg_q;
    assign DigitSel = sel_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_countdown_display.sv
// Self-checking bench for countdown_display and its bin2bcd_seq converter.
// Blink expectations follow COUNTDOWN_DISPLAY_BLINK_EN.
module tb_countdown_display;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] tl, tm, tr, pl, pr;
    logic [6:0] seg;
    logic [9:0] dsel;
    logic       busy;

    logic       b_start;
    logic [6:0] b_bin;
    logic       b_done;
    logic [3:0] b_tens, b_units;
    logic       b_over;

    int n_checks = 0;
    int n_errors = 0;
    logic [6:0] exp_q[$];

    always #5 clk = ~clk;

    countdown_display #(
        .TW(6), .PW(6), .ScanDiv(4), .RefreshDiv(64), .BlinkDiv(32)
    ) dut (
        .Clock(clk), .Reset(rst),
        .TLsec(tl), .TMsec(tm), .TRsec(tr), .PLsec(pl), .PRsec(pr),
        .Seg(seg), .DigitSel(dsel), .Busy(busy)
    );

    bin2bcd_seq #(.W(7)) u_bcd (
        .Clock(clk), .Reset(rst), .Start(b_start), .Bin(b_bin),
        .Done(b_done), .Tens(b_tens), .Units(b_units), .Over(b_over)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Active-low {g,f,e,d,c,b,a}; -1 blank, -2 dash.
    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b100_0000;
            1: return 7'b111_1001;
            2: return 7'b010_0100;
            3: return 7'b011_0000;
            4: return 7'b001_1001;
            5: return 7'b001_0010;
            6: return 7'b000_0010;
            7: return 7'b111_1000;
            8: return 7'b000_0000;
            9: return 7'b001_0000;
            -2: return 7'b011_1111;
            default: return 7'b111_1111;
        endcase
    endfunction

    function automatic logic [9:0] sel_of(input int d);
        logic [9:0] one;
        one = 10'd1;
        return ~(one << d);
    endfunction

    task automatic push_channel(input int v);
        if (v > 99) begin
            exp_q.push_back(seg_of(-2));
            exp_q.push_back(seg_of(-2));
        end else if (v < 10) begin
            exp_q.push_back(seg_of(-1));
            exp_q.push_back(seg_of(v));
        end else begin
            exp_q.push_back(seg_of(v / 10));
            exp_q.push_back(seg_of(v % 10));
        end
    endtask

    task automatic push_all(input int a, input int b, input int c, input int d, input int e);
        push_channel(a); push_channel(b); push_channel(c); push_channel(d); push_channel(e);
    endtask

    task automatic wait_busy(input logic level, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (busy == level) ok = 1;
        end
        check_val(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_sweep();
        wait_busy(1'b1, "sweep_start");
        wait_busy(1'b0, "sweep_end");
    endtask

    task automatic align_digit(input int d, output bit found);
        logic [9:0] prev;
        found = 0;
        prev  = dsel;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (dsel == sel_of(d) && prev != dsel) found = 1;
            prev = dsel;
        end
    endtask

    // Scan checker: blank first cycle, expected digit from the scoreboard, 4-cycle dwell.
    task automatic check_digits(input int first, input int count);
        logic [9:0] cur_sel;
        logic [6:0] exp;
        int         dwell;
        bit         found;
        align_digit(first, found);
        check_val("align", 32'(found), 32'd1);
        for (int k = 0; k < count; k++) begin
            int d;
            d = (first + k) % 10;
            check_val($sformatf("sel_d%0d", d), 32'(dsel), 32'(sel_of(d)));
            check_val($sformatf("blank_d%0d", d), 32'(seg), 32'h7F);
            cur_sel = dsel;
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check_val("sb_empty", 32'd0, 32'd1);
            end else begin
                exp = exp_q.pop_front();
                check_val($sformatf("seg_d%0d", d), 32'(seg), 32'(exp));
            end
            dwell = 2;
            for (int j = 0; j < 8; j++) begin
                @(negedge clk);
                if (dsel != cur_sel) break;
                dwell++;
            end
            check_val($sformatf("dwell_d%0d", d), 32'(dwell), 32'd4);
        end
        check_val("next_sel", 32'(dsel), 32'(sel_of((first + count) % 10)));
    endtask

    task automatic grab_digit(input int d, output logic [6:0] s);
        bit found;
        align_digit(d, found);
        check_val("grab_align", 32'(found), 32'd1);
        @(negedge clk);
        s = seg;
    endtask

    task automatic run_bcd(input logic [6:0] bin, input logic exp_over,
                           input logic [3:0] exp_tens, input logic [3:0] exp_units);
        int         done_at, done_cnt;
        logic [3:0] t, u;
        logic       o;
        done_at = 0; done_cnt = 0; t = '0; u = '0; o = 1'b0;
        @(negedge clk);
        b_bin   = bin;
        b_start = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            b_start = (n == 3);
            if (n == 3) b_bin = 7'd5;
            if (b_done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = n; t = b_tens; u = b_units; o = b_over;
                end
            end
        end
        b_start = 1'b0;
        check_val($sformatf("bcd%0d_done_at", bin), 32'(done_at), 32'd8);
        check_val($sformatf("bcd%0d_done_len", bin), 32'(done_cnt), 32'd1);
        check_val($sformatf("bcd%0d_over", bin), 32'(o), 32'(exp_over));
        if (!exp_over) begin
            check_val($sformatf("bcd%0d_tens", bin), 32'(t), 32'(exp_tens));
            check_val($sformatf("bcd%0d_units", bin), 32'(u), 32'(exp_units));
        end
    endtask

    initial begin
        logic [6:0] s;
        int         seen_on, seen_off, seen_other;
        rst = 1'b1;
        tl = 6'd20; tm = 6'd42; tr = 6'd7; pl = 6'd46; pr = 6'd0;
        b_start = 1'b0; b_bin = '0;
        repeat (3) @(negedge clk);
        check_val("rst_seg", 32'(seg), 32'h7F);
        check_val("rst_sel", 32'(dsel), 32'h3FF);
        check_val("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // First sweep: full frame including the 9 -> 0 wrap.
        wait_sweep();
        push_all(20, 42, 7, 46, 0);
        check_digits(0, 10);

        // TL changes during channel 2 conversion: this commit keeps 20, next shows 19.
        wait_busy(1'b0, "mid_idle");
        wait_busy(1'b1, "mid_start");
        repeat (21) @(negedge clk);
        tl = 6'd19;
        wait_busy(1'b0, "mid_end");
        push_channel(20);
        check_digits(0, 2);
        wait_sweep();
        push_channel(19);
        check_digits(0, 2);

        // Largest 6-bit value.
        tl = 6'd63;
        wait_sweep();
        wait_sweep();
        push_all(63, 42, 7, 46, 0);
        check_digits(0, 10);

        // Async reset during a sweep: immediate blank, nothing committed, then recovery.
        wait_busy(1'b0, "rst_idle");
        wait_busy(1'b1, "rst_start");
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("arst_seg", 32'(seg), 32'h7F);
        check_val("arst_sel", 32'(dsel), 32'h3FF);
        check_val("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        push_channel(-1);
        exp_q.pop_back();
        exp_q.push_back(seg_of(-1));
        check_digits(2, 2);
        wait_sweep();
        push_all(63, 42, 7, 46, 0);
        check_digits(0, 10);

        // Converter boundaries, with a Start pulse mid-conversion that must be ignored.
        run_bcd(7'd120, 1'b1, 4'd0, 4'd0);
        run_bcd(7'd63, 1'b0, 4'd6, 4'd3);
        run_bcd(7'd99, 1'b0, 4'd9, 4'd9);
        run_bcd(7'd100, 1'b1, 4'd0, 4'd0);
        run_bcd(7'd0, 1'b0, 4'd0, 4'd0);

        // PR=2: blinks only with the feature enabled; TL=20 never blanks.
        tl = 6'd20; pr = 6'd2;
        wait_sweep();
        wait_sweep();
        for (int i = 0; i < 6; i++) begin
            push_channel(20);
            exp_q.pop_back();
            check_digits(0, 1);
        end
        seen_on = 0; seen_off = 0; seen_other = 0;
        for (int i = 0; i < 16; i++) begin
            grab_digit(9, s);
`ifdef COUNTDOWN_DISPLAY_BLINK_EN
            if (s == seg_of(2)) seen_on++;
            else if (s == seg_of(-1)) seen_off++;
            else seen_other++;
`else
            exp_q.push_back(seg_of(2));
            check_val($sformatf("pr_steady_%0d", i), 32'(s), 32'(exp_q.pop_front()));
`endif
        end
`ifdef COUNTDOWN_DISPLAY_BLINK_EN
        check_val("pr_blink_on", 32'(seen_on > 0), 32'd1);
        check_val("pr_blink_off", 32'(seen_off > 0), 32'd1);
        check_val("pr_blink_other", 32'(seen_other), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
